// File: rtl/rx_buffer_module.sv
// Receive-side byte buffer: captures bytes on the receiver's done edge into a FIFO
// and serves them through a request / registered-response read port with status.
module rx_buffer_module #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  RX_Done_Sig,
    input  logic [7:0]            RX_Data,
    output logic                  RX_En_Sig,
    input  logic                  Read_Req_Sig,
    output logic [7:0]            Read_Data,
    output logic                  Read_Valid_Sig,
    output logic                  Empty_Sig,
    output logic                  Full_Sig,
    output logic [DEPTH_LOG2:0]   Count,
    output logic                  Overflow_Sig,
    input  logic                  Clr_Sig
);

    localparam int unsigned         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE       = 1;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic                  done_q;
    logic                  wr;
    logic                  rd;
    logic                  wr_ok;
    logic [DEPTH_LOG2:0]   count_next;

    // A write while full is dropped even if a read frees a slot in the same cycle.
    always_comb begin
        wr         = RX_Done_Sig & ~done_q;
        rd         = Read_Req_Sig & ~Empty_Sig;
        wr_ok      = wr & ~Full_Sig;
        count_next = Count;
        if (Clr_Sig) begin
            count_next = '0;
        end else begin
            case ({wr_ok, rd})
                2'b10:   count_next = Count + ONE;
                2'b01:   count_next = Count - ONE;
                default: count_next = Count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_ok && !Clr_Sig) begin
            mem[wptr] <= RX_Data;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wptr           <= '0;
            rptr           <= '0;
            done_q         <= 1'b0;
            Count          <= '0;
            Empty_Sig      <= 1'b1;
            Full_Sig       <= 1'b0;
            Overflow_Sig   <= 1'b0;
            RX_En_Sig      <= 1'b0;
            Read_Data      <= '0;
            Read_Valid_Sig <= 1'b0;
        end else begin
            done_q    <= RX_Done_Sig;
            Count     <= count_next;
            Empty_Sig <= (count_next == '0);
            Full_Sig  <= (count_next == DEPTH_CNT);
            RX_En_Sig <= (count_next < DEPTH_CNT);
            if (Clr_Sig) begin
                wptr           <= '0;
                rptr           <= '0;
                Overflow_Sig   <= 1'b0;
                Read_Valid_Sig <= 1'b0;
            end else begin
                Read_Valid_Sig <= rd;
                if (wr_ok) begin
                    wptr <= wptr + 1'b1;
                end
                if (wr && Full_Sig) begin
                    Overflow_Sig <= 1'b1;
                end
                if (rd) begin
                    Read_Data <= mem[rptr];
                    rptr      <= rptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_buffer_module.sv
// Scoreboard bench for rx_buffer_module: a queue-based model predicts status and
// read bytes; a negedge monitor compares every cycle and pops expected read data.
module tb_rx_buffer_module;

    localparam int DEPTH = 16;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       RX_Done_Sig = 1'b0;
    logic [7:0] RX_Data = '0;
    logic       RX_En_Sig;
    logic       Read_Req_Sig = 1'b0;
    logic [7:0] Read_Data;
    logic       Read_Valid_Sig;
    logic       Empty_Sig;
    logic       Full_Sig;
    logic [4:0] Count;
    logic       Overflow_Sig;
    logic       Clr_Sig = 1'b0;

    rx_buffer_module #(.DEPTH_LOG2(4)) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .RX_Done_Sig    (RX_Done_Sig),
        .RX_Data        (RX_Data),
        .RX_En_Sig      (RX_En_Sig),
        .Read_Req_Sig   (Read_Req_Sig),
        .Read_Data      (Read_Data),
        .Read_Valid_Sig (Read_Valid_Sig),
        .Empty_Sig      (Empty_Sig),
        .Full_Sig       (Full_Sig),
        .Count          (Count),
        .Overflow_Sig   (Overflow_Sig),
        .Clr_Sig        (Clr_Sig)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic       m_prev  = 1'b0;
    logic       m_ovf   = 1'b0;
    logic       m_rxen  = 1'b0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = '0;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_prev  = 1'b0;
        m_ovf   = 1'b0;
        m_rxen  = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    // Drive one cycle of inputs, then advance the model across the edge.
    task automatic step(input logic done, input logic [7:0] data, input logic req, input logic clr);
        logic wr, rd, was_full;
        RX_Done_Sig  = done;
        RX_Data      = data;
        Read_Req_Sig = req;
        Clr_Sig      = clr;
        @(posedge CLK);
        wr       = done && !m_prev;
        rd       = req && (mq.size() != 0);
        was_full = (mq.size() == DEPTH);
        m_prev   = done;
        m_valid  = 1'b0;
        if (clr) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (rd) begin
                m_data  = mq.pop_front();
                m_valid = 1'b1;
                exp_q.push_back(m_data);
            end
            if (wr) begin
                if (was_full) m_ovf = 1'b1;
                else          mq.push_back(data);
            end
        end
        m_rxen = (mq.size() < DEPTH);
        #1;
    endtask

    task automatic wbyte(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0);
        step(1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic rbyte();
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Monitor: compares status every cycle and pops the scoreboard on each valid pulse.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge CLK);
            chk("count",    32'(Count),        32'(mq.size()));
            chk("empty",    32'(Empty_Sig),    32'(mq.size() == 0));
            chk("full",     32'(Full_Sig),     32'(mq.size() == DEPTH));
            chk("overflow", 32'(Overflow_Sig), 32'(m_ovf));
            chk("rx_en",    32'(RX_En_Sig),    32'(m_rxen));
            chk("rd_valid", 32'(Read_Valid_Sig), 32'(m_valid));
            chk("rd_hold",  32'(Read_Data),    32'(m_data));
            if (Read_Valid_Sig) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", 32'(Read_Data), 32'(e));
                end
            end else if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1'b1;
        idle(2);

        // Basic three-byte round trip
        wbyte(8'hA5); wbyte(8'h3C); wbyte(8'h0F);
        rbyte(); rbyte(); rbyte();
        idle(2);

        // Level-held done yields one write
        for (int i = 0; i < 5; i++) step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        rbyte();
        idle(1);

        // Fill, overflow, drain, sticky overflow, clear
        for (int i = 0; i < 16; i++) wbyte(8'(i));
        wbyte(8'hFF);
        for (int i = 0; i < 16; i++) rbyte();
        idle(2);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle(1);

        // Simultaneous write and read: empty, count 4, full
        step(1'b1, 8'h11, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        rbyte();
        for (int i = 0; i < 4; i++) wbyte(8'h20 + 8'(i));
        step(1'b1, 8'h99, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) wbyte(8'h40 + 8'(i));
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) rbyte();

        // Read while empty leaves data and valid alone
        rbyte(); rbyte();
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Pointer wrap
        for (int i = 0; i < 10; i++) wbyte(8'h60 + 8'(i));
        for (int i = 0; i < 10; i++) rbyte();
        for (int i = 0; i < 10; i++) wbyte(8'h80 + 8'(i));
        for (int i = 0; i < 10; i++) rbyte();

        // Asynchronous reset between edges
        wbyte(8'hC1); wbyte(8'hC2);
        step(1'b1, 8'hC3, 1'b1, 1'b0);
        #2;
        RSTn = 1'b0;
        RX_Done_Sig = 1'b0; Read_Req_Sig = 1'b0; Clr_Sig = 1'b0;
        model_reset();
        #1;
        chk("arst_count", 32'(Count), 32'(0));
        chk("arst_empty", 32'(Empty_Sig), 32'(1));
        chk("arst_full",  32'(Full_Sig), 32'(0));
        chk("arst_ovf",   32'(Overflow_Sig), 32'(0));
        chk("arst_rx_en", 32'(RX_En_Sig), 32'(0));
        chk("arst_valid", 32'(Read_Valid_Sig), 32'(0));
        chk("arst_data",  32'(Read_Data), 32'(0));
        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1'b1;
        idle(2);

        // Randomized traffic in fill-heavy and drain-heavy phases
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 400; i++) begin
                step(1'($urandom_range(0, 1)), 8'($urandom),
                     ($urandom_range(0, 99) < ((p % 2 == 0) ? 20 : 75)),
                     ($urandom_range(0, 149) == 0));
            end
        end

        idle(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
